// File: rtl/sdrc_bram_emulator.sv
// BRAM-backed responder for the Gowin SDRAM HS controller user interface.
// Reproduces the controller's ack and read-data timing so it can stand in for real SDRAM.
module sdrc_bram_emulator #(
  parameter int DepthBitWidth   = 10,
  parameter int InitCycles      = 16,
  parameter int ActiveAckDelay  = 2,
  parameter int ReadLatency     = 4,
  parameter int WriteAckDelay   = 3,
  parameter int RefreshAckDelay = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic [20:0] I_sdrc_addr,
  input  logic [7:0]  I_sdrc_data_len,
  input  logic [31:0] I_sdrc_data,
  input  logic [3:0]  I_sdrc_dqm,
  input  logic        I_sdrc_precharge_ctrl,
  input  logic        I_sdram_power_down,
  input  logic        I_sdram_selfrefresh,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack,
  output logic        protocol_error
);

  localparam int Depth = 2**DepthBitWidth;
  localparam logic [2:0] CmdRef = 3'b001, CmdAct = 3'b011, CmdWr = 3'b100, CmdRd = 3'b101;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACT_WAIT, S_REF_WAIT, S_WR_BURST, S_WR_ACK, S_RD_WAIT, S_RD_BURST
  } state_t;

  state_t state_q, state_d;
  logic [15:0] icnt_q, icnt_d;
  logic [4:0]  dcnt_q, dcnt_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [DepthBitWidth-1:0] ptr_q, ptr_d, mem_addr, cmd_addr;
  logic [20:0] act_addr_q, act_addr_d;
  logic ack_d, err_d, init_d, wr_done, mem_we, mem_re;
  logic [31:0] mem [Depth];

  assign cmd_addr = I_sdrc_addr[DepthBitWidth-1:0];

  logic unused_ok;
  assign unused_ok = ^{I_sdrc_addr[20:DepthBitWidth], I_sdrc_precharge_ctrl,
                       I_sdram_power_down, I_sdram_selfrefresh, act_addr_q};

  always_comb begin
    state_d    = state_q;
    icnt_d     = icnt_q;
    dcnt_d     = dcnt_q;
    bcnt_d     = bcnt_q;
    ptr_d      = ptr_q;
    act_addr_d = act_addr_q;
    ack_d      = 1'b0;
    err_d      = protocol_error;
    init_d     = O_sdrc_init_done;
    wr_done    = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = ptr_q;
    // Any strobe outside Idle (including the ack cycle itself) is a protocol violation.
    if (I_sdrc_cmd_en && (state_q != S_IDLE || O_sdrc_cmd_ack)) err_d = 1'b1;
    case (state_q)
      S_INIT: begin
        if (icnt_q == 16'(InitCycles - 1)) begin
          state_d = S_IDLE;
          init_d  = 1'b1;
        end else icnt_d = icnt_q + 1'b1;
      end
      S_IDLE: if (I_sdrc_cmd_en && !O_sdrc_cmd_ack) begin
        case (I_sdrc_cmd)
          CmdAct: begin
            act_addr_d = I_sdrc_addr;
            if (ActiveAckDelay == 1) ack_d = 1'b1;
            else begin state_d = S_ACT_WAIT; dcnt_d = 5'(ActiveAckDelay - 2); end
          end
          CmdRef: begin
            if (RefreshAckDelay == 1) ack_d = 1'b1;
            else begin state_d = S_REF_WAIT; dcnt_d = 5'(RefreshAckDelay - 2); end
          end
          CmdWr: begin
            mem_we   = 1'b1;
            mem_addr = cmd_addr;
            ptr_d    = cmd_addr + 1'b1;
            bcnt_d   = I_sdrc_data_len;
            if (I_sdrc_data_len == 8'd0) wr_done = 1'b1;
            else state_d = S_WR_BURST;
          end
          CmdRd: begin
            ptr_d   = cmd_addr;
            bcnt_d  = I_sdrc_data_len;
            dcnt_d  = 5'(ReadLatency - 2);
            state_d = S_RD_WAIT;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_ACT_WAIT, S_REF_WAIT, S_WR_ACK: begin
        if (dcnt_q == 5'd0) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else dcnt_d = dcnt_q - 1'b1;
      end
      S_WR_BURST: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        bcnt_d = bcnt_q - 1'b1;
        if (bcnt_q == 8'd1) wr_done = 1'b1;
      end
      // Address goes to the BRAM one cycle before the word appears on O_sdrc_data.
      S_RD_WAIT: begin
        if (dcnt_q == 5'd0) begin
          mem_re = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (bcnt_q == 8'd0) begin
            ack_d   = 1'b1;
            state_d = S_IDLE;
          end else state_d = S_RD_BURST;
        end else dcnt_d = dcnt_q - 1'b1;
      end
      S_RD_BURST: begin
        mem_re = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        bcnt_d = bcnt_q - 1'b1;
        if (bcnt_q == 8'd1) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    if (wr_done) begin
      if (WriteAckDelay == 1) begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = S_WR_ACK;
        dcnt_d  = 5'(WriteAckDelay - 2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_INIT;
      icnt_q           <= '0;
      dcnt_q           <= '0;
      bcnt_q           <= '0;
      ptr_q            <= '0;
      act_addr_q       <= '0;
      O_sdrc_cmd_ack   <= 1'b0;
      protocol_error   <= 1'b0;
      O_sdrc_init_done <= 1'b0;
    end else begin
      state_q          <= state_d;
      icnt_q           <= icnt_d;
      dcnt_q           <= dcnt_d;
      bcnt_q           <= bcnt_d;
      ptr_q            <= ptr_d;
      act_addr_q       <= act_addr_d;
      O_sdrc_cmd_ack   <= ack_d;
      protocol_error   <= err_d;
      O_sdrc_init_done <= init_d;
    end
  end

  // Storage is never reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n)
      for (int b = 0; b < 4; b++)
        if (!I_sdrc_dqm[b]) mem[mem_addr][8*b +: 8] <= I_sdrc_data[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) O_sdrc_data <= '0;
    else if (mem_re) O_sdrc_data <= mem[mem_addr];
  end

endmodule

// File: tb/tb_sdrc_bram_emulator.sv
// Randomized scoreboard bench for sdrc_bram_emulator: expected acks and read words are queued
// with their due cycle at issue time and compared by an independent monitor.
module tb_sdrc_bram_emulator;

  localparam int DEPTH = 1024, INIT = 16, AAD = 2, RL = 4, WAD = 3, RAD = 4;

  logic        clk = 1'b0, rst_n = 1'b0, cmd_en = 1'b0;
  logic [2:0]  cmd = '0;
  logic [20:0] addr = '0;
  logic [7:0]  len = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  dqm = '0;
  logic        pc = 1'b0, pd = 1'b0, sr = 1'b0;
  logic [31:0] rdata;
  logic        init_done, ack, perr;

  sdrc_bram_emulator dut (
    .clk(clk), .rst_n(rst_n), .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_addr(addr),
    .I_sdrc_data_len(len), .I_sdrc_data(wdata), .I_sdrc_dqm(dqm),
    .I_sdrc_precharge_ctrl(pc), .I_sdram_power_down(pd), .I_sdram_selfrefresh(sr),
    .O_sdrc_data(rdata), .O_sdrc_init_done(init_done), .O_sdrc_cmd_ack(ack),
    .protocol_error(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] d; } rd_ev_t;
  rd_ev_t rdq[$];
  int ackq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  wm [256];
  int n_cmp = 0, n_bad = 0;
  int rel_cyc = 1 << 30, err_cyc = -1, next_ok = 0;
  logic [31:0] exp_hold = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compares every output once per cycle, away from the active edge.
  always @(negedge clk) begin
    rd_ev_t ev;
    if (rst_n) begin
      check("init_done", 32'(init_done), 32'(cyc >= rel_cyc + INIT));
      check("protocol_error", 32'(perr), 32'(err_cyc >= 0 && cyc >= err_cyc));
      if (rdq.size() > 0 && rdq[0].c == cyc) begin
        ev = rdq.pop_front();
        check("read_word", rdata, ev.d);
        exp_hold = ev.d;
      end else check("read_hold", rdata, exp_hold);
      if (ackq.size() > 0 && ackq[0] == cyc) begin
        void'(ackq.pop_front());
        check("ack_pulse", 32'(ack), 32'd1);
      end else check("ack_quiet", 32'(ack), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    while (cyc < next_ok) step();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    cmd_en = 1'b0;
    rdq.delete();
    ackq.delete();
    err_cyc = -1;
    exp_hold = '0;
    rel_cyc = 1 << 30;
    repeat (n) step();
    rst_n = 1'b1;
    rel_cyc = cyc;
    next_ok = cyc + INIT;
  endtask

  task automatic flag_err();
    if (err_cyc < 0) err_cyc = cyc + 1;
  endtask

  task automatic cmd_simple(logic [2:0] c, int dly);
    wait_ready();
    cmd_en = 1'b1; cmd = c; addr = 21'($urandom); len = 8'($urandom);
    ackq.push_back(cyc + dly);
    next_ok = cyc + dly + 1;
    step();
    cmd_en = 1'b0;
  endtask

  task automatic cmd_write(logic [20:0] a, int l);
    int idx;
    wait_ready();
    ackq.push_back(cyc + l + WAD);
    next_ok = cyc + l + WAD + 1;
    cmd_en = 1'b1; cmd = 3'b100; addr = a; len = 8'(l);
    for (int k = 0; k <= l; k++) begin
      wdata = wd[k];
      dqm = wm[k];
      idx = (int'(a) + k) % DEPTH;
      for (int b = 0; b < 4; b++)
        if (!wm[k][b]) model[idx][8*b +: 8] = wd[k][8*b +: 8];
      step();
      cmd_en = 1'b0;
    end
    wdata = $urandom;
    dqm = 4'($urandom);
  endtask

  task automatic cmd_read(logic [20:0] a, int l);
    rd_ev_t ev;
    wait_ready();
    for (int k = 0; k <= l; k++) begin
      ev.c = cyc + RL + k;
      ev.d = model[(int'(a) + k) % DEPTH];
      rdq.push_back(ev);
    end
    ackq.push_back(cyc + RL + l);
    next_ok = cyc + RL + l + 1;
    cmd_en = 1'b1; cmd = 3'b101; addr = a; len = 8'(l);
    step();
    cmd_en = 1'b0;
  endtask

  initial begin
    int r, l;
    logic [20:0] a;
    step();
    do_reset(20);
    // command during init: flagged, never acked
    repeat (5) step();
    cmd_en = 1'b1; cmd = 3'b011; flag_err();
    step();
    cmd_en = 1'b0;
    wait_ready();
    repeat (3) step();
    do_reset(20);

    // fill all storage with 256-word bursts; upper address bits must be ignored
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin wd[k] = $urandom; wm[k] = 4'h0; end
      a = (21'($urandom) & 21'h1FFC00) | 21'(blk * 256);
      cmd_write(a, 255);
    end
    cmd_simple(3'b011, AAD);
    cmd_simple(3'b001, RAD);

    for (int k = 0; k < 8; k++) begin wd[k] = 32'h1000 + 32'(k); wm[k] = 4'h0; end
    cmd_write(21'h40, 7);
    cmd_read(21'h40, 7);

    // wrap at the top of storage with a partial byte mask on word 1
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hFFFF_FFFF; wm[k] = 4'h0; end
    cmd_write(21'h3FE, 3);
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; wm[k] = 4'h0; end
    wm[1] = 4'b0011;
    cmd_write(21'h3FE, 3);
    cmd_read(21'h3FE, 3);
    cmd_read(21'($urandom), 255);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = 21'($urandom);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      repeat ($urandom_range(0, 3)) step();
      if (r == 0) cmd_simple(3'b011, AAD);
      else if (r == 1) cmd_simple(3'b001, RAD);
      else if (r < 6) begin
        for (int k = 0; k <= l; k++) begin wd[k] = $urandom; wm[k] = 4'($urandom); end
        cmd_write(a, l);
      end else cmd_read(a, l);
    end

    // strobe while a read is in flight: flagged, read unaffected
    cmd_read(21'h40, 7);
    step();
    cmd_en = 1'b1; cmd = 3'($urandom); addr = 21'($urandom); flag_err();
    step();
    cmd_en = 1'b0;
    wait_ready();
    cmd_en = 1'b1; cmd = 3'b010;
    flag_err();
    step();
    cmd_en = 1'b0;
    cmd_read(21'h3FE, 3);

    // reset mid-read: no ack, init restarts, storage survives
    cmd_read(21'h100, 7);
    step();
    step();
    do_reset(5);
    cmd_read(21'h40, 7);
    wait_ready();
    repeat (5) step();
    check("queues_drained", 32'(rdq.size() + ackq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
